// File: rtl/muldiv_sequencer_if.sv
`default_nettype none
// ============================================================================
// muldiv_sequencer_if : start/operand handshake and HI/LO result buses
// Rev 1.0
// ============================================================================
interface muldiv_sequencer_if;
    logic        op_start;
    logic        op_sel;
    logic [31:0] operand_a;
    logic [31:0] operand_b;
    logic        busy;
    logic        done;
    logic        div_by_zero;
    logic [31:0] mult_msb;
    logic [31:0] mult_lsb;
    logic [31:0] div_remainder;
    logic [31:0] div_quotient;
    logic        HI_mux_control;
    logic        LO_mux_control;
    logic        HI_control;
    logic        LO_control;

    modport master (
        output op_start, op_sel, operand_a, operand_b,
        input  busy, done, div_by_zero, mult_msb, mult_lsb, div_remainder,
               div_quotient, HI_mux_control, LO_mux_control, HI_control, LO_control
    );

    modport slave (
        input  op_start, op_sel, operand_a, operand_b,
        output busy, done, div_by_zero, mult_msb, mult_lsb, div_remainder,
               div_quotient, HI_mux_control, LO_mux_control, HI_control, LO_control
    );
endinterface
`default_nettype wire

// File: rtl/muldiv_sequencer.sv
`default_nettype none
// ============================================================================
// muldiv_sequencer : iterative signed Booth multiply / restoring divide with
// HI/LO write sequencing. Optional macro MULDIV_DIVZERO_TRAP_EN enables the
// divide-by-zero trap path.
// Rev 1.0
// ============================================================================
module muldiv_sequencer (
    input  wire logic         clk,
    input  wire logic         reset,
    muldiv_sequencer_if.slave bus
);
    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_MULT   = 3'd1;
    localparam logic [2:0] S_DIV    = 3'd2;
    localparam logic [2:0] S_DIVFIX = 3'd3;
    localparam logic [2:0] S_WRITE  = 3'd4;
`ifdef MULDIV_DIVZERO_TRAP_EN
    localparam logic [2:0] S_DZERO  = 3'd5;
`endif

    logic [2:0]  state_q, state_d;
    logic [5:0]  cnt_q, cnt_d;
    logic [31:0] a_q, a_d, b_q, b_d;
    logic [65:0] booth_q, booth_d;
    logic [31:0] rem_q, rem_d, quo_q, quo_d;
    logic [31:0] mult_msb_q, mult_msb_d, mult_lsb_q, mult_lsb_d;
    logic [31:0] div_rem_q, div_rem_d, div_quo_q, div_quo_d;
    logic        sel_mult_q, sel_mult_d;

    // Booth register: [65:33] 33-bit accumulator (headroom for -2^31), [32:1] multiplier, [0] q(-1)
    logic [32:0] w_m_ext, w_acc_sum;
    logic [65:0] w_booth_next;
    assign w_m_ext = {a_q[31], a_q};
    always_comb begin
        w_acc_sum = booth_q[65:33];
        case (booth_q[1:0])
            2'b01:   w_acc_sum = booth_q[65:33] + w_m_ext;
            2'b10:   w_acc_sum = booth_q[65:33] - w_m_ext;
            default: w_acc_sum = booth_q[65:33];
        endcase
    end
    assign w_booth_next = {w_acc_sum[32], w_acc_sum, booth_q[32:1]};

    logic [31:0] w_divisor_abs;
    logic [32:0] w_shift;
    logic [33:0] w_diff;
    logic [31:0] w_quo_fix, w_rem_fix;
    assign w_divisor_abs = b_q[31] ? -b_q : b_q;
    assign w_shift       = {rem_q, quo_q[31]};
    assign w_diff        = {1'b0, w_shift} - {2'b00, w_divisor_abs};
    assign w_quo_fix     = (a_q[31] ^ b_q[31]) ? -quo_q : quo_q;
    assign w_rem_fix     = a_q[31] ? -rem_q : rem_q;

    logic w_unused;
    assign w_unused = ^{w_diff[32], w_booth_next[65], w_booth_next[0]};

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        a_d        = a_q;
        b_d        = b_q;
        booth_d    = booth_q;
        rem_d      = rem_q;
        quo_d      = quo_q;
        mult_msb_d = mult_msb_q;
        mult_lsb_d = mult_lsb_q;
        div_rem_d  = div_rem_q;
        div_quo_d  = div_quo_q;
        sel_mult_d = sel_mult_q;
        case (state_q)
            S_IDLE: begin
                if (bus.op_start) begin
                    a_d        = bus.operand_a;
                    b_d        = bus.operand_b;
                    cnt_d      = 6'd0;
                    sel_mult_d = ~bus.op_sel;
                    booth_d    = {33'd0, bus.operand_b, 1'b0};
                    rem_d      = 32'd0;
                    quo_d      = bus.operand_a[31] ? -bus.operand_a : bus.operand_a;
                    if (!bus.op_sel)
                        state_d = S_MULT;
`ifdef MULDIV_DIVZERO_TRAP_EN
                    else if (bus.operand_b == 32'd0)
                        state_d = S_DZERO;
`endif
                    else
                        state_d = S_DIV;
                end
            end
            S_MULT: begin
                booth_d = w_booth_next;
                cnt_d   = cnt_q + 6'd1;
                if (cnt_q == 6'd31) begin
                    mult_msb_d = w_booth_next[64:33];
                    mult_lsb_d = w_booth_next[32:1];
                    state_d    = S_WRITE;
                end
            end
            S_DIV: begin
                quo_d = {quo_q[30:0], ~w_diff[33]};
                rem_d = w_diff[33] ? w_shift[31:0] : w_diff[31:0];
                cnt_d = cnt_q + 6'd1;
                if (cnt_q == 6'd31)
                    state_d = S_DIVFIX;
            end
            S_DIVFIX: begin
`ifdef MULDIV_DIVZERO_TRAP_EN
                div_quo_d = w_quo_fix;
                div_rem_d = w_rem_fix;
`else
                // Untrapped zero divisor: MIPS-style all-ones quotient, dividend as remainder
                div_quo_d = (b_q == 32'd0) ? 32'hFFFF_FFFF : w_quo_fix;
                div_rem_d = (b_q == 32'd0) ? a_q : w_rem_fix;
`endif
                state_d = S_WRITE;
            end
            S_WRITE: state_d = S_IDLE;
`ifdef MULDIV_DIVZERO_TRAP_EN
            S_DZERO: state_d = S_IDLE;
`endif
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            cnt_q      <= 6'd0;
            a_q        <= 32'd0;
            b_q        <= 32'd0;
            booth_q    <= 66'd0;
            rem_q      <= 32'd0;
            quo_q      <= 32'd0;
            mult_msb_q <= 32'd0;
            mult_lsb_q <= 32'd0;
            div_rem_q  <= 32'd0;
            div_quo_q  <= 32'd0;
            sel_mult_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            a_q        <= a_d;
            b_q        <= b_d;
            booth_q    <= booth_d;
            rem_q      <= rem_d;
            quo_q      <= quo_d;
            mult_msb_q <= mult_msb_d;
            mult_lsb_q <= mult_lsb_d;
            div_rem_q  <= div_rem_d;
            div_quo_q  <= div_quo_d;
            sel_mult_q <= sel_mult_d;
        end
    end

    assign bus.busy           = (state_q != S_IDLE);
    assign bus.HI_control     = (state_q == S_WRITE);
    assign bus.LO_control     = (state_q == S_WRITE);
`ifdef MULDIV_DIVZERO_TRAP_EN
    assign bus.done           = (state_q == S_WRITE) || (state_q == S_DZERO);
    assign bus.div_by_zero    = (state_q == S_DZERO);
`else
    assign bus.done           = (state_q == S_WRITE);
    assign bus.div_by_zero    = 1'b0;
`endif
    assign bus.HI_mux_control = sel_mult_q;
    assign bus.LO_mux_control = sel_mult_q;
    assign bus.mult_msb       = mult_msb_q;
    assign bus.mult_lsb       = mult_lsb_q;
    assign bus.div_remainder  = div_rem_q;
    assign bus.div_quotient   = div_quo_q;
endmodule
`default_nettype wire

// File: tb/tb_muldiv_sequencer.sv
`default_nettype none
// ============================================================================
// tb_muldiv_sequencer : directed self-checking bench for muldiv_sequencer
// Rev 1.0
// ============================================================================
module tb_muldiv_sequencer;
    logic clk = 1'b0;
    logic reset;
    int   errors = 0;
    int   checks = 0;

    muldiv_sequencer_if bus ();

    muldiv_sequencer u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Accept in cycle N, return sampled in the done cycle; lat is the offset from N.
    task automatic run_op(input logic sel, input logic [31:0] a, input logic [31:0] b,
                          input bit disturb, output int lat, output logic busy1);
        bus.op_start  = 1'b1;
        bus.op_sel    = sel;
        bus.operand_a = a;
        bus.operand_b = b;
        @(posedge clk); #1;
        bus.op_start  = 1'b0;
        bus.operand_a = 32'hDEAD_BEEF;
        bus.operand_b = 32'h0BAD_F00D;
        busy1 = bus.busy;
        lat   = 1;
        while (!bus.done && lat < 60) begin
            if (disturb && lat == 5) begin
                bus.op_start  = 1'b1;
                bus.op_sel    = ~sel;
                bus.operand_a = 32'h1234_5678;
            end else begin
                bus.op_start  = 1'b0;
            end
            @(posedge clk); #1;
            lat++;
        end
        bus.op_start = 1'b0;
    endtask

    task automatic check_idle_after(input string tag);
        @(posedge clk); #1;
        check({tag, "_done_drop"}, {31'd0, bus.done}, 32'd0);
        check({tag, "_busy_drop"}, {31'd0, bus.busy}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int   lat;
        logic busy1;

        reset         = 1'b1;
        bus.op_start  = 1'b0;
        bus.op_sel    = 1'b0;
        bus.operand_a = 32'd0;
        bus.operand_b = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy",  {31'd0, bus.busy}, 32'd0);
        check("rst_done",  {31'd0, bus.done}, 32'd0);
        check("rst_dbz",   {31'd0, bus.div_by_zero}, 32'd0);
        check("rst_hi_en", {31'd0, bus.HI_control}, 32'd0);
        check("rst_lo_en", {31'd0, bus.LO_control}, 32'd0);
        check("rst_hisel", {31'd0, bus.HI_mux_control}, 32'd0);
        check("rst_losel", {31'd0, bus.LO_mux_control}, 32'd0);
        check("rst_msb",   bus.mult_msb, 32'd0);
        check("rst_lsb",   bus.mult_lsb, 32'd0);
        check("rst_rem",   bus.div_remainder, 32'd0);
        check("rst_quo",   bus.div_quotient, 32'd0);
        reset = 1'b0;
        @(posedge clk); #1;

        // 7 * -3 = -21
        run_op(1'b0, 32'd7, 32'hFFFF_FFFD, 1'b0, lat, busy1);
        check("m1_busy1", {31'd0, busy1}, 32'd1);
        check("m1_lat",   lat, 32'd33);
        check("m1_msb",   bus.mult_msb, 32'hFFFF_FFFF);
        check("m1_lsb",   bus.mult_lsb, 32'hFFFF_FFEB);
        check("m1_hi_en", {31'd0, bus.HI_control}, 32'd1);
        check("m1_lo_en", {31'd0, bus.LO_control}, 32'd1);
        check("m1_hisel", {31'd0, bus.HI_mux_control}, 32'd1);
        check("m1_losel", {31'd0, bus.LO_mux_control}, 32'd1);
        check("m1_busy",  {31'd0, bus.busy}, 32'd1);
        check_idle_after("m1");
        check("m1_hi_en_drop", {31'd0, bus.HI_control}, 32'd0);

        // -2^31 * -2^31 = 2^62
        run_op(1'b0, 32'h8000_0000, 32'h8000_0000, 1'b0, lat, busy1);
        check("m2_lat", lat, 32'd33);
        check("m2_msb", bus.mult_msb, 32'h4000_0000);
        check("m2_lsb", bus.mult_lsb, 32'h0000_0000);
        check_idle_after("m2");

        // 100 * 200 with a stray op_start and operand_a change mid-op
        run_op(1'b0, 32'd100, 32'd200, 1'b1, lat, busy1);
        check("m3_lat", lat, 32'd33);
        check("m3_msb", bus.mult_msb, 32'h0000_0000);
        check("m3_lsb", bus.mult_lsb, 32'h0000_4E20);
        check_idle_after("m3");
        check("m3_no_queue", {31'd0, bus.busy}, 32'd0);

        // -7 / 2 = -3 rem -1
        run_op(1'b1, 32'hFFFF_FFF9, 32'd2, 1'b0, lat, busy1);
        check("d1_busy1", {31'd0, busy1}, 32'd1);
        check("d1_lat",   lat, 32'd34);
        check("d1_quo",   bus.div_quotient, 32'hFFFF_FFFD);
        check("d1_rem",   bus.div_remainder, 32'hFFFF_FFFF);
        check("d1_hi_en", {31'd0, bus.HI_control}, 32'd1);
        check("d1_hisel", {31'd0, bus.HI_mux_control}, 32'd0);
        check("d1_losel", {31'd0, bus.LO_mux_control}, 32'd0);
        check("d1_dbz",   {31'd0, bus.div_by_zero}, 32'd0);
        check("d1_keep_lsb", bus.mult_lsb, 32'h0000_4E20);
        check_idle_after("d1");

        // Overflow case: -2^31 / -1
        run_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, lat, busy1);
        check("d2_lat", lat, 32'd34);
        check("d2_quo", bus.div_quotient, 32'h8000_0000);
        check("d2_rem", bus.div_remainder, 32'h0000_0000);
        check("d2_dbz", {31'd0, bus.div_by_zero}, 32'd0);
        check_idle_after("d2");

        // 100 / -7 = -14 rem 2
        run_op(1'b1, 32'd100, 32'hFFFF_FFF9, 1'b0, lat, busy1);
        check("d3_lat", lat, 32'd34);
        check("d3_quo", bus.div_quotient, 32'hFFFF_FFF2);
        check("d3_rem", bus.div_remainder, 32'h0000_0002);
        check_idle_after("d3");

        // 5 / 0
        run_op(1'b1, 32'd5, 32'd0, 1'b0, lat, busy1);
`ifdef MULDIV_DIVZERO_TRAP_EN
        check("dz_lat",   lat, 32'd1);
        check("dz_dbz",   {31'd0, bus.div_by_zero}, 32'd1);
        check("dz_hi_en", {31'd0, bus.HI_control}, 32'd0);
        check("dz_lo_en", {31'd0, bus.LO_control}, 32'd0);
        check("dz_quo",   bus.div_quotient, 32'hFFFF_FFF2);
        check("dz_rem",   bus.div_remainder, 32'h0000_0002);
`else
        check("dz_lat",   lat, 32'd34);
        check("dz_dbz",   {31'd0, bus.div_by_zero}, 32'd0);
        check("dz_hi_en", {31'd0, bus.HI_control}, 32'd1);
        check("dz_lo_en", {31'd0, bus.LO_control}, 32'd1);
        check("dz_quo",   bus.div_quotient, 32'hFFFF_FFFF);
        check("dz_rem",   bus.div_remainder, 32'h0000_0005);
`endif
        check("dz_keep_lsb", bus.mult_lsb, 32'h0000_4E20);
        check_idle_after("dz");
        check("dz_dbz_drop", {31'd0, bus.div_by_zero}, 32'd0);

        // Reset during iteration 10 of a divide
        bus.op_start  = 1'b1;
        bus.op_sel    = 1'b1;
        bus.operand_a = 32'd1000;
        bus.operand_b = 32'd3;
        @(posedge clk); #1;
        bus.op_start  = 1'b0;
        repeat (10) @(posedge clk);
        #3;
        check("rm_busy_pre", {31'd0, bus.busy}, 32'd1);
        reset = 1'b1;
        #1;
        check("rm_busy",  {31'd0, bus.busy}, 32'd0);
        check("rm_done",  {31'd0, bus.done}, 32'd0);
        check("rm_hi_en", {31'd0, bus.HI_control}, 32'd0);
        check("rm_losel", {31'd0, bus.LO_mux_control}, 32'd0);
        check("rm_lsb",   bus.mult_lsb, 32'd0);
        check("rm_quo",   bus.div_quotient, 32'd0);
        check("rm_rem",   bus.div_remainder, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (bus.done) check("rm_spurious_done", {31'd0, bus.done}, 32'd0);
        end
        check("rm_idle", {31'd0, bus.busy}, 32'd0);

        // -5 * 6 = -30 after reset recovery
        run_op(1'b0, 32'hFFFF_FFFB, 32'd6, 1'b0, lat, busy1);
        check("m4_lat",   lat, 32'd33);
        check("m4_msb",   bus.mult_msb, 32'hFFFF_FFFF);
        check("m4_lsb",   bus.mult_lsb, 32'hFFFF_FFE2);
        check("m4_hisel", {31'd0, bus.HI_mux_control}, 32'd1);
        check_idle_after("m4");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/muldiv_sequencer.md
# muldiv_sequencer

Iterative signed multiply/divide engine and HI/LO write sequencer for the multicycle MIPS datapath. It runs on a single start pulse from the control unit and latches its operands from the A/B registers. It produces the four result buses that feed the HI and LO muxes, drives those muxes' selects and the HI/LO register load enables, and reports completion and divide-by-zero back to the control unit.

## Interface
Parameters:
- none; widths fixed at 32-bit operands, 6-bit iteration counter.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high.
- op_start  in  1  request; sampled only in IDLE.
- op_sel  in  1  0 = mult, 1 = div; sampled with op_start.
- operand_a  in  32  rs value (A register output); multiplicand / dividend.
- operand_b  in  32  rt value (B register output); multiplier / divisor.
- busy  out  1  high from the start-accept edge until the sequencer returns to IDLE.
- done  out  1  one-cycle completion pulse.
- div_by_zero  out  1  one-cycle pulse, coincident with done.
- mult_msb  out  32  product bits 63:32, to the HI mux.
- mult_lsb  out  32  product bits 31:0, to the LO mux.
- div_remainder  out  32  to the HI mux.
- div_quotient  out  32  to the LO mux.
- HI_mux_control  out  1  0 = div_remainder, 1 = mult_msb.
- LO_mux_control  out  1  0 = div_quotient, 1 = mult_lsb.
- HI_control  out  1  HI register load enable.
- LO_control  out  1  LO register load enable.

## Operation
- States: IDLE, MULT, DIV, DIVFIX, WRITE, DZERO.
- IDLE, op_start=1:
  - Latch operand_a and operand_b into internal registers; later changes on the inputs are ignored.
  - Clear the iteration counter.
  - op_sel=0 → MULT.
  - op_sel=1 and operand_b≠0 → DIV.
  - op_sel=1 and operand_b=0 → DZERO.
- MULT: radix-2 Booth, signed two's complement, 32 iterations, one per cycle, 64-bit product.
  - Counter reaching 31 → WRITE.
  - Result loads into mult_msb/mult_lsb on the final-iteration edge.
- DIV: restoring division on the absolute values, 32 iterations, one per cycle.
  - Counter reaching 31 → DIVFIX.
- DIVFIX: sign correction.
  - Quotient is negated if the operand signs differ (truncation toward zero).
  - Remainder takes the sign of the dividend.
  - Result loads into div_quotient/div_remainder, then → WRITE.
  - 0x80000000 / 0xFFFFFFFF gives quotient 0x80000000, remainder 0, with no flag.
- WRITE: HI_control=LO_control=1 and done=1 for exactly one cycle, then → IDLE.
  - Mux selects are 1 for mult and 0 for div.
- DZERO: done=1 and div_by_zero=1 for one cycle, then → IDLE.
  - HI_control and LO_control stay 0; HI, LO and the result buses are unchanged.
- Mux selects hold the type of the last accepted op until the next accept.
- Result buses hold their last values until the same op type completes again.
- op_start while busy: ignored, with no queuing.

## Timing
- Reset values (asynchronous): state IDLE; busy, done, div_by_zero, HI_control, LO_control, both mux selects all 0; all four result buses 0x00000000.
- Reset mid-operation: immediate return to IDLE with all outputs at their reset values. No HI/LO load occurs; done is not pulsed.
- Take cycle N as the cycle with op_start high in IDLE:
  - busy is high from cycle N+1 through the done cycle inclusive.
  - mult: done and the load enables in cycle N+33; HI/LO update at the end of N+33; next op accepted in cycle N+34.
  - div: done in cycle N+34.
  - div by zero: done and div_by_zero in cycle N+1.
- done, HI_control and LO_control are registered outputs (state-decoded from a registered state); they are never combinational from op_start.

## Configuration
- MULDIV_DIVZERO_TRAP_EN defined: divide-by-zero behaves as above (DZERO path, flagged, no HI/LO write).
- Not defined:
  - DZERO state is absent and div_by_zero is tied to 0.
  - A zero divisor runs the normal 34-cycle div sequence.
  - DIVFIX forces div_quotient=0xFFFFFFFF and div_remainder=latched dividend, and HI/LO are written.

## Test plan
- mult 7 × −3 → done in cycle N+33; mult_msb=0xFFFFFFFF, mult_lsb=0xFFFFFFEB; HI_control=LO_control=1 and both selects=1 for one cycle.
- mult 0x80000000 × 0x80000000 → mult_msb=0x40000000, mult_lsb=0x00000000.
- div −7 / 2 → done in cycle N+34; div_quotient=0xFFFFFFFD (−3), div_remainder=0xFFFFFFFF (−1); selects=0.
- div 5 / 0 with the macro defined → done=div_by_zero=1 in cycle N+1; HI_control=LO_control=0; result buses unchanged. Without the macro: done in N+34, quotient 0xFFFFFFFF, remainder 5, loads asserted.
- op_start pulsed again during MULT, and operand_a changed mid-op → no effect; original result still produced at N+33.
- reset asserted at iteration 10 of a div → immediately IDLE with all outputs 0; no done pulse; a new mult accepted after deassertion completes normally.
